// File: rtl/demux1x2_router.sv
// demux1x2_router: steers one WIDTH-bit word stream into two FIFO'd channels.
// Ports: in_* producer side, a_*/b_* consumer sides with levels, stat_a/stat_b.
// Optional macro DEMUX1X2_STATS_EN builds the per-channel accept counters.

module demux1x2_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop_req,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop;

  assign valid = (level != '0);
  assign full  = (level == LW'(DEPTH));
  assign rdata = mem[rd_ptr];

  // pop requests against an empty FIFO are ignored
  assign pop = pop_req & valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // DEPTH is a power of two, so natural overflow wraps the pointers
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

module demux1x2_router #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [LW-1:0]    a_level,
  output logic [LW-1:0]    b_level,
  output logic [15:0]      stat_a,
  output logic [15:0]      stat_b
);

  logic a_full;
  logic b_full;
  logic a_push;
  logic b_push;

  // only the selected channel's fullness matters; consumer ready
  // never feeds back so a full FIFO refuses even while it pops
  assign in_ready = in_sel ? ~b_full : ~a_full;
  assign a_push   = in_valid & in_ready & ~in_sel;
  assign b_push   = in_valid & in_ready &  in_sel;

  demux1x2_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (a_push),
    .wdata   (in_data),
    .pop_req (a_ready),
    .rdata   (a_data),
    .valid   (a_valid),
    .full    (a_full),
    .level   (a_level)
  );

  demux1x2_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (b_push),
    .wdata   (in_data),
    .pop_req (b_ready),
    .rdata   (b_data),
    .valid   (b_valid),
    .full    (b_full),
    .level   (b_level)
  );

`ifdef DEMUX1X2_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_a <= '0;
      stat_b <= '0;
    end else begin
      if (a_push) stat_a <= stat_a + 16'd1;
      if (b_push) stat_b <= stat_b + 16'd1;
    end
  end
`else
  assign stat_a = 16'h0000;
  assign stat_b = 16'h0000;
`endif

endmodule
